acc_ordered_commit: RTL and testbench

Ordered commit unit for one parallel-loop accumulator lane. It sits directly downstream of the per-core `acc_req_valid`/`acc_req_ready`/`acc_data`/`gc_stamp` outputs. It accepts partial values from all cores and folds them into a single accumulator strictly in global-counter (gc) order, so reduction results are bit-identical regardless of core timing. One instance is built per accumulator (N_ACC instances in the top level). Each addition goes through an external pipelined FP adder over a request/done handshake.

---
 rtl/acc_ordered_commit_pkg.sv | 22 ++
 rtl/acc_ordered_commit_arbiter.sv | 28 ++
 rtl/acc_ordered_commit.sv | 145 ++++++++++++++
 tb/tb_acc_ordered_commit.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/acc_ordered_commit_pkg.sv
// Shared widths and FSM state type for the ordered-commit accumulator lanes.
// Optional build macro: ACC_STAMP_CHECK_EN (stale-stamp detection in the top).
package acc_ordered_commit_pkg;

  localparam int N_CORE   = 4;
  localparam int GC_WIDTH = 16;
  localparam int GD_WIDTH = 8;
  localparam int N_ACC    = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEEK   = 2'd1,
    ST_ADD    = 2'd2,
    ST_FINISH = 2'd3
  } acc_commit_state_t;

  // The gc stride is signed; widening it lets the stamp advance wrap mod 2^GC_WIDTH.
  function automatic logic [GC_WIDTH-1:0] sext_gd(input logic [GD_WIDTH-1:0] d);
    return {{(GC_WIDTH-GD_WIDTH){d[GD_WIDTH-1]}}, d};
  endfunction

endpackage

// File: rtl/acc_ordered_commit_arbiter.sv
// Stamp-match arbiter: finds cores whose stamp equals the expected gc and
// grants the lowest-index one (one-hot) with its data.
module acc_ordered_commit_arbiter
  import acc_ordered_commit_pkg::*;
(
  input  logic [N_CORE-1:0]   valid,
  input  logic [GC_WIDTH-1:0] stamp [N_CORE],
  input  logic [31:0]         data  [N_CORE],
  input  logic [GC_WIDTH-1:0] next_stamp,
  output logic                hit,
  output logic [N_CORE-1:0]   grant,
  output logic [31:0]         sel_data
);

  always_comb begin
    hit      = 1'b0;
    grant    = '0;
    sel_data = '0;
    for (int i = 0; i < N_CORE; i++) begin
      if (!hit && valid[i] && (stamp[i] == next_stamp)) begin
        hit      = 1'b1;
        grant[i] = 1'b1;
        sel_data = data[i];
      end
    end
  end

endmodule

// File: rtl/acc_ordered_commit.sv
// Ordered commit lane: folds per-core partial values into one accumulator in gc order.
// Optional build macro: ACC_STAMP_CHECK_EN (flag and drop requests stamped behind next_stamp).
//
// state  | meaning
// IDLE   | no parallel region active
// SEEK   | looking for the request stamped next_stamp
// ADD    | one addition in flight, waiting for add_done
// FINISH | region drained, commit_done pulses next
module acc_ordered_commit
  import acc_ordered_commit_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                issue_fork,
  input  logic [GC_WIDTH-1:0] fork_gc,
  input  logic [GD_WIDTH-1:0] fork_gd,
  input  logic [31:0]         init_value,
  input  logic [N_CORE-1:0]   acc_req_valid,
  input  logic [31:0]         acc_data [N_CORE],
  input  logic [GC_WIDTH-1:0] gc_stamp [N_CORE],
  output logic [N_CORE-1:0]   acc_req_ready,
  output logic                add_req,
  output logic [31:0]         add_a,
  output logic [31:0]         add_b,
  input  logic                add_done,
  input  logic [31:0]         add_result,
  input  logic                all_ending,
  output logic [31:0]         acc_value,
  output logic                commit_done,
  output logic                stamp_error
);

  acc_commit_state_t   state;
  logic [GC_WIDTH-1:0] next_stamp;
  logic [GD_WIDTH-1:0] gd;
  logic                busy;
  logic                hit;
  logic [N_CORE-1:0]   grant;
  logic [31:0]         sel_data;

  acc_ordered_commit_arbiter u_arbiter (
    .valid      (acc_req_valid),
    .stamp      (gc_stamp),
    .data       (acc_data),
    .next_stamp (next_stamp),
    .hit        (hit),
    .grant      (grant),
    .sel_data   (sel_data)
  );

  assign add_a = acc_value;

`ifdef ACC_STAMP_CHECK_EN
  logic [N_CORE-1:0]   stale;
  logic [GC_WIDTH-1:0] diff;

  // A stamp is behind when it lies on the far side of next_stamp from the stride direction.
  always_comb begin
    stale = '0;
    diff  = '0;
    for (int i = 0; i < N_CORE; i++) begin
      diff = gc_stamp[i] - next_stamp;
      if (acc_req_valid[i]) begin
        if (gd[GD_WIDTH-1])
          stale[i] = !diff[GC_WIDTH-1] && (diff != '0);
        else
          stale[i] = diff[GC_WIDTH-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      stamp_error <= 1'b0;
    else if ((state == ST_SEEK) && !issue_fork && (|stale))
      stamp_error <= 1'b1;
  end
`else
  assign stamp_error = 1'b0;
`endif

  // A fork in the same cycle wins, so nothing is consumed for the region being abandoned.
  always_comb begin
    acc_req_ready = '0;
    if ((state == ST_SEEK) && !issue_fork) begin
`ifdef ACC_STAMP_CHECK_EN
      acc_req_ready = grant | stale;
`else
      acc_req_ready = grant;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      acc_value   <= '0;
      next_stamp  <= '0;
      gd          <= '0;
      add_b       <= '0;
      add_req     <= 1'b0;
      commit_done <= 1'b0;
      busy        <= 1'b0;
    end else begin
      add_req     <= 1'b0;
      commit_done <= 1'b0;
      if (issue_fork) begin
        acc_value  <= init_value;
        next_stamp <= fork_gc;
        gd         <= fork_gd;
        busy       <= 1'b0;
        state      <= ST_SEEK;
      end else begin
        case (state)
          ST_IDLE: state <= ST_IDLE;
          ST_SEEK: begin
            if (hit) begin
              add_b   <= sel_data;
              add_req <= 1'b1;
              busy    <= 1'b1;
              state   <= ST_ADD;
            end else if (all_ending && !(|acc_req_valid)) begin
              state <= ST_FINISH;
            end
          end
          ST_ADD: begin
            // busy guards against a result from an abandoned region
            if (add_done && busy) begin
              acc_value  <= add_result;
              next_stamp <= next_stamp + sext_gd(gd);
              busy       <= 1'b0;
              state      <= ST_SEEK;
            end
          end
          ST_FINISH: begin
            commit_done <= 1'b1;
            state       <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_acc_ordered_commit.sv
// Self-checking bench for acc_ordered_commit: region table, grant scoreboard,
// and a float adder model with fixed latency.
module tb_acc_ordered_commit;
  import acc_ordered_commit_pkg::*;

  localparam int LAT = 3;

  logic                clk = 1'b0;
  logic                reset;
  logic                issue_fork;
  logic [GC_WIDTH-1:0] fork_gc;
  logic [GD_WIDTH-1:0] fork_gd;
  logic [31:0]         init_value;
  logic [N_CORE-1:0]   acc_req_valid;
  logic [31:0]         acc_data [N_CORE];
  logic [GC_WIDTH-1:0] gc_stamp [N_CORE];
  logic [N_CORE-1:0]   acc_req_ready;
  logic                add_req;
  logic [31:0]         add_a, add_b;
  logic                add_done;
  logic [31:0]         add_result;
  logic                all_ending;
  logic [31:0]         acc_value;
  logic                commit_done;
  logic                stamp_error;

  acc_ordered_commit dut (
    .clk(clk), .reset(reset), .issue_fork(issue_fork), .fork_gc(fork_gc),
    .fork_gd(fork_gd), .init_value(init_value), .acc_req_valid(acc_req_valid),
    .acc_data(acc_data), .gc_stamp(gc_stamp), .acc_req_ready(acc_req_ready),
    .add_req(add_req), .add_a(add_a), .add_b(add_b), .add_done(add_done),
    .add_result(add_result), .all_ending(all_ending), .acc_value(acc_value),
    .commit_done(commit_done), .stamp_error(stamp_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] gc;
    logic [7:0]  gd;
    logic [31:0] init;
    int          first;
    int          n;
    logic [31:0] exp_acc;
    logic [15:0] exp_next;
  } region_t;

  typedef struct {
    int          core;
    logic [15:0] stamp;
    logic [31:0] data;
  } req_t;

  typedef struct {
    int          core;
    logic [31:0] data;
    bit          stale;
  } exp_t;

  region_t     regions [3];
  req_t        reqs [9];
  exp_t        sb [$];

  int          checks = 0;
  int          failures = 0;
  logic [31:0] acc_model;
  logic [31:0] pend_b;
  int          add_cnt;
  logic [31:0] add_res;
  logic        s_commit_done;
  logic        s_add_req;
  logic [N_CORE-1:0] s_ready;

  function automatic real f2r(input logic [31:0] f);
    logic [63:0] d;
    if (f[30:0] == '0) d = {f[31], 63'b0};
    else d = {f[31], 11'(int'(f[30:23]) - 127 + 1023), f[22:0], 29'b0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    d = $realtobits(r);
    if (d[62:0] == '0) return {d[63], 31'b0};
    return {d[63], 8'(int'(d[62:52]) - 1023 + 127), d[51:29]};
  endfunction

  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    return r2f(f2r(a) + f2r(b));
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: sample at negedge, score grants and add requests, update drivers after the edge.
  task automatic tick();
    logic [N_CORE-1:0] hs;
    logic              req_seen;
    logic [31:0]       a_s, b_s;
    exp_t              e;
    @(negedge clk);
    hs            = acc_req_valid & acc_req_ready;
    s_ready       = acc_req_ready;
    s_commit_done = commit_done;
    s_add_req     = add_req;
    for (int i = 0; i < N_CORE; i++) begin
      if (hs[i]) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_grant: core %0d granted, expected no grant", i);
        end else begin
          e = sb.pop_front();
          check("grant_core", 32'(i), 32'(e.core));
          check("grant_data", acc_data[i], e.data);
          if (!e.stale) pend_b = e.data;
        end
      end
    end
    if (add_req) begin
      check("add_a", add_a, acc_model);
      check("add_b", add_b, pend_b);
      acc_model = fadd(acc_model, pend_b);
    end
    req_seen = add_req;
    a_s = add_a;
    b_s = add_b;
    @(posedge clk);
    #1;
    for (int i = 0; i < N_CORE; i++)
      if (hs[i]) acc_req_valid[i] = 1'b0;
    add_done = 1'b0;
    if (add_cnt > 0) begin
      add_cnt--;
      if (add_cnt == 0) begin
        add_done   = 1'b1;
        add_result = add_res;
      end
    end
    if (req_seen) begin
      add_cnt = LAT;
      add_res = fadd(a_s, b_s);
    end
  endtask

  task automatic start_region(input logic [15:0] gc, input logic [7:0] gd, input logic [31:0] init);
    issue_fork = 1'b1;
    fork_gc    = gc;
    fork_gd    = gd;
    init_value = init;
    tick();
    issue_fork = 1'b0;
    acc_model  = init;
  endtask

  task automatic offer(input int core, input logic [15:0] stamp, input logic [31:0] data);
    acc_req_valid[core] = 1'b1;
    gc_stamp[core]      = stamp;
    acc_data[core]      = data;
  endtask

  task automatic wait_sb_empty(input string name);
    int n = 0;
    while (sb.size() > 0 && n < 300) begin
      tick();
      n++;
    end
    checks++;
    if (sb.size() > 0) begin
      failures++;
      $display("FAIL %s_timeout: %0d grants outstanding, expected 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic finish_region(input string name);
    int n = 0;
    bit seen = 0;
    all_ending = 1'b1;
    while (!seen && n < 10) begin
      tick();
      if (s_commit_done) seen = 1;
      else n++;
    end
    checks++;
    if (!seen || n != 2) begin
      failures++;
      $display("FAIL %s_commit_latency: got %0d cycles (seen=%0d) expected 2", name, n, seen);
    end
    all_ending = 1'b0;
    tick();
    check({name, "_commit_pulse"}, {31'b0, s_commit_done}, 32'd0);
  endtask

  task automatic run_region(input string name, input region_t r);
    logic [15:0] s;
    int          found;
    exp_t        e;
    start_region(r.gc, r.gd, r.init);
    for (int k = 0; k < r.n; k++)
      offer(reqs[r.first+k].core, reqs[r.first+k].stamp, reqs[r.first+k].data);
    s = r.gc;
    for (int k = 0; k < r.n; k++) begin
      found = -1;
      for (int j = 0; j < r.n; j++)
        if (reqs[r.first+j].stamp == s &&
            (found < 0 || reqs[r.first+j].core < reqs[r.first+found].core))
          found = j;
      if (found >= 0) begin
        e.core  = reqs[r.first+found].core;
        e.data  = reqs[r.first+found].data;
        e.stale = 0;
        sb.push_back(e);
      end
      s = s + 16'($signed(r.gd));
    end
    wait_sb_empty(name);
    repeat (LAT + 4) tick();
    check({name, "_acc"}, acc_value, r.exp_acc);
    check({name, "_acc_model"}, acc_value, acc_model);
    check({name, "_next_stamp"}, 32'(dut.next_stamp), 32'(r.exp_next));
    finish_region(name);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   n;

    regions = '{
      '{16'h0000, 8'h01, 32'h00000000, 0, 4, 32'h41200000, 16'h0004},
      '{16'h000A, 8'hFE, 32'h3F800000, 4, 3, 32'h40A00000, 16'h0004},
      '{16'hFFFF, 8'h01, 32'h00000000, 7, 2, 32'h40400000, 16'h0001}
    };
    reqs = '{
      '{3, 16'h0003, 32'h40800000}, '{2, 16'h0002, 32'h40400000},
      '{1, 16'h0001, 32'h40000000}, '{0, 16'h0000, 32'h3F800000},
      '{2, 16'h000A, 32'h3F000000}, '{0, 16'h0008, 32'h3FC00000},
      '{1, 16'h0006, 32'h40000000},
      '{0, 16'h0000, 32'h40000000}, '{1, 16'hFFFF, 32'h3F800000}
    };

    reset = 1'b1; issue_fork = 1'b0; fork_gc = '0; fork_gd = '0; init_value = '0;
    acc_req_valid = '0; add_done = 1'b0; add_result = '0; all_ending = 1'b0;
    for (int i = 0; i < N_CORE; i++) begin
      acc_data[i] = '0;
      gc_stamp[i] = '0;
    end
    acc_model = '0; pend_b = '0; add_cnt = 0; add_res = '0;
    s_commit_done = 1'b0; s_add_req = 1'b0; s_ready = '0;

    repeat (3) tick();
    check("rst_acc_value", acc_value, 32'h0);
    check("rst_add_req", {31'b0, add_req}, 32'd0);
    check("rst_commit_done", {31'b0, commit_done}, 32'd0);
    check("rst_ready", 32'(acc_req_ready), 32'd0);
    check("rst_stamp_error", {31'b0, stamp_error}, 32'd0);
    check("rst_next_stamp", 32'(dut.next_stamp), 32'd0);
    reset = 1'b0;
    tick();

    run_region("ordered", regions[0]);
    run_region("neg_stride", regions[1]);
    run_region("wrap", regions[2]);

    // Two cores on the same stamp: lower index wins, the other stays pending.
    start_region(16'd5, 8'h01, 32'h0);
    offer(1, 16'd5, 32'h3FC00000);
    offer(2, 16'd5, 32'h40000000);
    e.core = 1; e.data = 32'h3FC00000; e.stale = 0;
    sb.push_back(e);
    wait_sb_empty("dup");
    check("dup_core2_ready", {31'b0, s_ready[2]}, 32'd0);
    check("dup_core2_pending", {31'b0, acc_req_valid[2]}, 32'd1);
    acc_req_valid[2] = 1'b0;
    repeat (LAT + 4) tick();
    check("dup_acc", acc_value, 32'h3FC00000);
    check("dup_next_stamp", 32'(dut.next_stamp), 32'd6);
    finish_region("dup");

    // Restart while an addition is in flight; its late result must be dropped.
    start_region(16'd0, 8'h01, 32'h3F800000);
    offer(0, 16'd0, 32'h40000000);
    e.core = 0; e.data = 32'h40000000; e.stale = 0;
    sb.push_back(e);
    n = 0;
    s_add_req = 1'b0;
    while (!s_add_req && n < 50) begin
      tick();
      n++;
    end
    check("restart_add_req_seen", {31'b0, s_add_req}, 32'd1);
    start_region(16'd100, 8'h01, 32'h40A00000);
    repeat (LAT + 4) tick();
    check("restart_acc", acc_value, 32'h40A00000);
    check("restart_next_stamp", 32'(dut.next_stamp), 32'd100);
    finish_region("restart");

    // Request stamped behind next_stamp.
    start_region(16'd4, 8'h01, 32'h0);
    offer(0, 16'd2, 32'h3F800000);
`ifdef ACC_STAMP_CHECK_EN
    e.core = 0; e.data = 32'h3F800000; e.stale = 1;
    sb.push_back(e);
    wait_sb_empty("stale");
    tick();
    check("stale_error", {31'b0, stamp_error}, 32'd1);
    check("stale_acc", acc_value, 32'h0);
`else
    repeat (6) tick();
    check("stale_pending", {31'b0, acc_req_valid[0]}, 32'd1);
    check("stale_error", {31'b0, stamp_error}, 32'd0);
    acc_req_valid[0] = 1'b0;
`endif
    finish_region("stale");

    // Reset in the middle of an addition returns everything to idle.
    start_region(16'd20, 8'h01, 32'h40400000);
    offer(3, 16'd20, 32'h3F800000);
    e.core = 3; e.data = 32'h3F800000; e.stale = 0;
    sb.push_back(e);
    n = 0;
    s_add_req = 1'b0;
    while (!s_add_req && n < 50) begin
      tick();
      n++;
    end
    reset = 1'b1;
    tick();
    check("midrst_acc", acc_value, 32'h0);
    check("midrst_stamp_error", {31'b0, stamp_error}, 32'd0);
    check("midrst_ready", 32'(acc_req_ready), 32'd0);
    check("midrst_next_stamp", 32'(dut.next_stamp), 32'd0);
    reset = 1'b0;
    repeat (LAT + 2) tick();
    check("midrst_late_done", acc_value, 32'h0);
    acc_req_valid = '0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
